multiplicador_8bits_seq: RTL and testbench



---
 rtl/multiplicador_8bits_seq_if.sv | 14 +
 rtl/multiplicador_8bits_seq.sv | 95 +++++++++
 tb/tb_multiplicador_8bits_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/multiplicador_8bits_seq_if.sv
// Start/busy/done handshake and operand/product bus for the sequential multiplier.
interface multiplicador_8bits_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] P;
  logic               busy;
  logic               done;

  modport master (output start, output A, output B, input P, input busy, input done);
  modport slave  (input start, input A, input B, output P, output busy, output done);
endinterface

// File: rtl/multiplicador_8bits_seq.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Optional: define MULT_ZERO_BYPASS_EN to skip CALC when either operand is zero.
module multiplicador_8bits_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  multiplicador_8bits_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mreg;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   add_sum;
  logic             zero_op;

  // Conditional add of the multiplicand; the carry becomes the top bit shifted into acc.
  always_comb begin
    add_sum = {1'b0, acc};
    if (mreg[0]) add_sum = {1'b0, acc} + {1'b0, mcand};
  end

  assign zero_op = (bus.A == '0) || (bus.B == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      acc      <= '0;
      mreg     <= '0;
      count    <= '0;
      bus.P    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            mcand <= bus.A;
            mreg  <= bus.B;
            acc   <= '0;
            count <= '0;
`ifdef MULT_ZERO_BYPASS_EN
            if (zero_op) begin
              bus.P    <= '0;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              bus.busy <= 1'b1;
              state    <= CALC;
            end
`else
            bus.busy <= 1'b1;
            state    <= CALC;
`endif
          end
        end
        CALC: begin
          acc   <= add_sum[WIDTH:1];
          mreg  <= {add_sum[0], mreg[WIDTH-1:1]};
          count <= count + CW'(1);
          // Last iteration: publish the shifted {acc,mreg} pair directly.
          if (count == CW'(WIDTH - 1)) begin
            bus.P    <= {add_sum, mreg[WIDTH-1:1]};
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Operand-zero detection is only consumed by the bypass path.
  logic unused_zero;
  assign unused_zero = zero_op;

endmodule

// File: tb/tb_multiplicador_8bits_seq.sv
// Directed-vector bench for multiplicador_8bits_seq: product, latency, busy width, hold and reset.
module tb_multiplicador_8bits_seq;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  multiplicador_8bits_seq_if #(.WIDTH(WIDTH)) mif ();

  multiplicador_8bits_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Caller is at a negedge. Optionally pulses a bogus start at CALC sample glitch_at,
  // or asserts async reset mid-cycle at sample rst_at (which aborts the operation).
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p, input int exp_lat,
                        input int glitch_at, input int rst_at);
    int n;
    int busy_cnt;
    logic [15:0] p_before;
    p_before   = mif.P;
    mif.A      = a;
    mif.B      = b;
    mif.start  = 1'b1;
    @(negedge clk);
    mif.start  = 1'b0;
    mif.A      = 8'hA5;
    mif.B      = 8'h5A;
    n = 1;
    busy_cnt = 0;
    while (mif.done !== 1'b1 && n < 20) begin
      if (mif.busy === 1'b1) busy_cnt++;
      if (n == 2 || n == 5) chk({tag, "_phold"}, 32'(mif.P), 32'(p_before));
      if (rst_at != 0 && n == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk({tag, "_rst_p"}, 32'(mif.P), 32'h0);
        chk({tag, "_rst_busy"}, 32'(mif.busy), 32'h0);
        chk({tag, "_rst_done"}, 32'(mif.done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (glitch_at != 0 && n == glitch_at) begin
        mif.start = 1'b1; mif.A = 8'd2; mif.B = 8'd2;
      end else begin
        mif.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    mif.start = 1'b0;
    chk({tag, "_timeout"}, 32'(mif.done), 32'h1);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    chk({tag, "_busy_at_done"}, 32'(mif.busy), 32'h0);
    chk({tag, "_p"}, 32'(mif.P), 32'(exp_p));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(mif.done), 32'h0);
    chk({tag, "_p_hold"}, 32'(mif.P), 32'(exp_p));
  endtask

  initial begin
    int dcnt;
    int zero_lat;
    n_chk = 0;
    n_pass = 0;
    mif.start = 1'b0;
    mif.A = '0;
    mif.B = '0;
    rst = 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
    zero_lat = 1;
`else
    zero_lat = 9;
`endif
    repeat (2) @(negedge clk);
    chk("reset_p", 32'(mif.P), 32'h0);
    chk("reset_busy", 32'(mif.busy), 32'h0);
    chk("reset_done", 32'(mif.done), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("m13x11",  8'd13,  8'd11,  16'h008F, 9, 0, 0);
    run_op("m255x255", 8'd255, 8'd255, 16'hFE01, 9, 0, 0);
    run_op("m1x200",  8'd1,   8'd200, 16'h00C8, 9, 0, 0);
    run_op("m0x200",  8'd0,   8'd200, 16'h0000, zero_lat, 0, 0);
    run_op("m200x0",  8'd200, 8'd0,   16'h0000, zero_lat, 0, 0);
    run_op("m128x2",  8'd128, 8'd2,   16'h0100, 9, 0, 0);

    run_op("m6x7_glitch", 8'd6, 8'd7, 16'h002A, 9, 3, 0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (mif.done === 1'b1 || mif.busy === 1'b1) dcnt++;
      @(negedge clk);
    end
    chk("glitch_no_restart", 32'(dcnt), 32'h0);

    run_op("m200x100_rst", 8'd200, 8'd100, 16'h0000, 9, 0, 4);
    run_op("m3x5_after_rst", 8'd3, 8'd5, 16'h000F, 9, 0, 0);

    // Back-to-back: second start is driven in the IDLE cycle right after done.
    run_op("b2b_12x12", 8'd12, 8'd12, 16'h0090, 9, 0, 0);
    run_op("b2b_9x9",   8'd9,  8'd9,  16'h0051, 9, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
